// File: rtl/button_debouncer_if.sv
// Signal bundle between a raw key pin and its debouncer.
// The master side drives the raw level; the slave (debouncer) returns clean events.
interface button_debouncer_if #(
  parameter int EVENT_WIDTH = 8
);

  logic                   btn_in;
  logic                   btn_level;
  logic                   press_pulse;
  logic                   release_pulse;
  logic [EVENT_WIDTH-1:0] press_count;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );

endinterface

// File: rtl/button_debouncer.sv
// Debounces one mechanical key into a clean level plus one-cycle press/release strobes.
// press_pulse is registered so it can trigger the downstream monostable directly.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 5,
  parameter int EVENT_WIDTH     = 8
) (
  input  logic              clk,
  input  logic              reset,
  button_debouncer_if.slave btn
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   sync1;
  logic                   s;
  state_t                 state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;
  logic [EVENT_WIDTH-1:0] count_q;

  // Two-flop synchronizer; the raw pin is asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn.btn_in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            count_q <= count_q + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A return to high is bounce: go back to PRESSED without any strobe.
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random bounce,
// compared every cycle against a run-length model of the debounce rule.
module tb_button_debouncer;

  localparam int DC = 4;

  logic clk;
  logic reset;

  button_debouncer_if #(.EVENT_WIDTH(8)) bus ();

  button_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .COUNT_WIDTH    (5),
    .EVENT_WIDTH    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: the FSM sees btn_in two edges late, and the level flips once
  // the seen value has differed from it for DC+1 consecutive edges.
  logic       m_level;
  int         m_run;
  logic       m_p1;
  logic       m_p2;
  logic       m_press;
  logic       m_release;
  logic [7:0] m_count;

  int step_no;
  int last_press_step;
  int last_release_step;
  int press_total;
  int release_total;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h at step %0d", tag, obs, exp, step_no);
      end
  endtask

  task automatic model_clear();
    m_level   = 1'b0;
    m_run     = 0;
    m_p1      = 1'b0;
    m_p2      = 1'b0;
    m_press   = 1'b0;
    m_release = 1'b0;
    m_count   = 8'd0;
  endtask

  task automatic compare_all();
    check_output("btn_level", 32'(bus.btn_level), 32'(m_level));
    check_output("press_pulse", 32'(bus.press_pulse), 32'(m_press));
    check_output("release_pulse", 32'(bus.release_pulse), 32'(m_release));
    check_output("press_count", 32'(bus.press_count), 32'(m_count));
    check_output("pulse_exclusive", 32'(bus.press_pulse & bus.release_pulse), 32'd0);
  endtask

  task automatic mark();
    step_no           = 0;
    last_press_step   = 0;
    last_release_step = 0;
    press_total       = 0;
    release_total     = 0;
  endtask

  task automatic apply_stimulus(input logic v);
    logic seen;
    bus.btn_in = v;
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      seen      = m_p2;
      m_p2      = m_p1;
      m_p1      = v;
      m_press   = 1'b0;
      m_release = 1'b0;
      m_run     = (seen != m_level) ? m_run + 1 : 0;
      if (m_run == DC + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          m_press = 1'b1;
          m_count = m_count + 8'd1;
        end else begin
          m_release = 1'b1;
        end
      end
    end
    #1;
    step_no++;
    if (bus.press_pulse === 1'b1) begin
      press_total++;
      last_press_step = step_no;
    end
    if (bus.release_pulse === 1'b1) begin
      release_total++;
      last_release_step = step_no;
    end
    compare_all();
  endtask

  task automatic apply_level(input logic v, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(v);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_clear();
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] bounce;
    bounce     = 8'b0011_0011;
    reset      = 1'b1;
    bus.btn_in = 1'b1;
    model_clear();
    mark();
    #2;

    // Button held through reset deassertion counts as a fresh press.
    assert_reset();
    apply_level(1'b1, 3);
    reset = 1'b1;
    mark();
    apply_level(1'b1, 10);
    check_output("held_reset_latency", 32'(last_press_step), 32'd7);
    check_output("held_reset_presses", 32'(press_total), 32'd1);
    check_output("held_reset_count", 32'(bus.press_count), 32'd1);

    // Clean press from idle.
    apply_level(1'b0, 12);
    mark();
    apply_level(1'b1, 20);
    check_output("clean_latency", 32'(last_press_step), 32'd7);
    check_output("clean_presses", 32'(press_total), 32'd1);
    check_output("clean_releases", 32'(release_total), 32'd0);
    check_output("clean_count", 32'(bus.press_count), 32'd2);

    // Two-cycle toggling never survives the debounce window.
    apply_level(1'b0, 12);
    mark();
    for (int i = 7; i >= 0; i--) apply_stimulus(bounce[i]);
    apply_level(1'b0, 10);
    check_output("bounce_presses", 32'(press_total), 32'd0);
    check_output("bounce_level", 32'(bus.btn_level), 32'd0);
    apply_level(1'b1, 10);
    check_output("bounce_then_press", 32'(press_total), 32'd1);

    // Release with a 2-cycle high glitch; strobe lands 7 edges after it ends.
    mark();
    apply_level(1'b0, 2);
    apply_level(1'b1, 2);
    apply_level(1'b0, 12);
    check_output("release_latency", 32'(last_release_step), 32'd11);
    check_output("release_count", 32'(release_total), 32'd1);
    check_output("release_no_press", 32'(press_total), 32'd0);
    check_output("release_level", 32'(bus.btn_level), 32'd0);

    // Wrap of press_count.
    assert_reset();
    apply_stimulus(1'b0);
    reset = 1'b1;
    mark();
    for (int p = 1; p <= 256; p++) begin
      apply_level(1'b1, 10);
      apply_level(1'b0, 10);
      if (p == 255) check_output("count_at_255", 32'(bus.press_count), 32'd255);
    end
    check_output("count_wrapped", 32'(bus.press_count), 32'd0);
    check_output("wrap_presses", 32'(press_total), 32'd256);

    // Reset while in PRESS_WAIT abandons the pending press.
    mark();
    apply_level(1'b1, 4);
    assert_reset();
    apply_level(1'b1, 3);
    check_output("abandoned_press", 32'(press_total), 32'd0);
    reset = 1'b1;
    mark();
    apply_level(1'b1, 10);
    check_output("reset_wait_latency", 32'(last_press_step), 32'd7);
    check_output("reset_wait_presses", 32'(press_total), 32'd1);
    check_output("reset_wait_count", 32'(bus.press_count), 32'd1);

    // Random bounce with occasional long stable stretches.
    for (int seg = 0; seg < 400; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = (seg % 4 == 3) ? int'($urandom_range(DC + 3, DC + 10)) : int'($urandom_range(1, DC + 2));
      apply_level(lvl, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions one raw mechanical push-button input, such as a vote key or the officer "ballot enable" key, into clean single-cycle press/release events.
- press_pulse drives the trigger input of the downstream pulse-stretching (monostable) stage directly.
- One instance per key sits between the board pin and the pulse stage.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a level change; legal range 2..2**COUNT_WIDTH.
- COUNT_WIDTH, 5: width of the internal stability counter.
- EVENT_WIDTH, 8: width of press_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- btn_in  input  1  raw button level, asynchronous to clk, 1 = pressed.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on accepted 0->1 of btn_level; feeds the monostable trigger.
- release_pulse  output  1  one-cycle strobe on accepted 1->0 of btn_level.
- press_count  output  EVENT_WIDTH  running count of accepted presses.

Behaviour:
- Reset (reset=0, asynchronous): sync flops=0, state=IDLE, counter=0, btn_level=0, press_pulse=0, release_pulse=0, press_count=0.
- Synchronizer: 2 flops, sync1<=btn_in, s<=sync1. The FSM sees only s.
- FSM states:
  - IDLE (stable low): s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: s=0 -> IDLE, cnt<=0 (bounce rejected, no output). Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED with btn_level<=1, press_pulse<=1, press_count<=press_count+1. Otherwise cnt<=cnt+1.
  - PRESSED (stable high): s=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT: s=1 -> PRESSED, cnt<=0. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE with btn_level<=0, release_pulse<=1. Otherwise cnt<=cnt+1.
- Pulses are registered and high for exactly one cycle; they are deasserted on every cycle without a commit. press_pulse and release_pulse are never high in the same cycle.
- Latency: for a clean input step, the strobe and the btn_level change appear DEBOUNCE_CYCLES+3 rising edges after btn_in changes (2 synchronizer edges, 1 FSM entry edge, DEBOUNCE_CYCLES count edges).
- Minimum event spacing: a press and its release are at least DEBOUNCE_CYCLES+1 cycles apart.
- Bounce: any glitch of s lasting fewer than DEBOUNCE_CYCLES+1 cycles produces no strobe, leaves btn_level unchanged and restarts the count from 0 on the next deviation.
- press_count: modulo 2**EVENT_WIDTH, wraps from max to 0 without flagging. Releases are not counted.
- Reset mid-operation: any WAIT state is abandoned with no strobe.
- Button held through reset deassertion: treated as a new press; press_pulse is issued DEBOUNCE_CYCLES+3 edges after reset rises.
- The counter never exceeds DEBOUNCE_CYCLES-1. No combinational path from btn_in to any output.

Test Plan:
- Run with DEBOUNCE_CYCLES=4. Hold reset=0, btn_in=1, release reset -> all outputs 0 during reset; after release, press_pulse high for 1 cycle at edge 7, btn_level=1, press_count=1.
- Clean press from idle: btn_in 0->1 held 20 cycles -> press_pulse exactly 1 cycle, 7 edges after the change; btn_level=1; press_count 0->1; release_pulse stays 0.
- Bounce rejection: btn_in toggles 1,0,1,0 every 2 cycles, then stays 0 -> no press_pulse, btn_level=0, press_count=0. Then a stable 1 for 10 cycles -> single press_pulse.
- Release: from PRESSED, btn_in 1->0 with one 2-cycle high glitch at cycle 3 -> release_pulse once, 7 edges after the glitch ends; btn_level=0; press_count unchanged.
- Wrap: 256 clean presses, each held and released for 10 cycles -> press_count reads 255 after press 255 and 0 after press 256; exactly 256 press_pulse strobes.
- Reset mid-PRESS_WAIT: press btn_in, pull reset low 4 edges later for 3 cycles while btn_in stays 1 -> no strobe before or during reset; one press_pulse 7 edges after reset release; press_count=1.
